// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline package for the operand forwarding logic.
// Holds the forwarding-select encodings and the hardwired-zero register
// specifier used by forwarding_unit and fwd_select.
package forwarding_unit_pkg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  // R0 always reads as zero, so it is never a forwarding target.
  localparam int unsigned ZERO_REG = 0;

endpackage : forwarding_unit_pkg

// File: rtl/forwarding_unit_fwd_select.sv
// fwd_select: forwarding-source select for one ID/EX source operand.
// Ports:
//   rs                  source register of the operand in ID/EX
//   reg_write_en_exmem  EX/MEM instruction writes a register
//   rd_exmem            EX/MEM destination register
//   reg_write_en_memwb  MEM/WB instruction writes a register
//   rd_memwb            MEM/WB destination register
//   sel                 2'b00 regfile, 2'b01 EX/MEM, 2'b10 MEM/WB
// Purely combinational; EX/MEM holds the newer value so it wins over MEM/WB.
module fwd_select
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  reg_write_en_exmem,
  input  logic [REG_ADDR_W-1:0] rd_exmem,
  input  logic                  reg_write_en_memwb,
  input  logic [REG_ADDR_W-1:0] rd_memwb,
  output logic [1:0]            sel
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = reg_write_en_exmem && (rd_exmem != ZERO) && (rd_exmem == rs);
  assign hit_memwb = reg_write_en_memwb && (rd_memwb != ZERO) && (rd_memwb == rs);

  always_comb begin
    sel = FWD_REGFILE;
    if (rs != ZERO) begin
      if (hit_exmem) begin
        sel = FWD_EXMEM;
      end else if (hit_memwb) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule : fwd_select

// File: rtl/forwarding_unit.sv
// forwarding_unit: data-hazard forwarding selects for both ID/EX operands,
// plus optional forwarding statistics counters.
// Build option: define FORWARDING_UNIT_STATS_EN to implement the counters;
// otherwise the count ports are tied to 0 and no counter state exists.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   Rs1_idex, Rs2_idex            ID/EX source registers
//   reg_write_en_exmem, Rd_exmem  EX/MEM write enable / destination
//   reg_write_en_memwb, Rd_memwb  MEM/WB write enable / destination
//   forward_A, forward_B          operand source selects (combinational)
//   fwd_exmem_count               cycles with any operand from EX/MEM
//   fwd_memwb_count               cycles with any operand from MEM/WB
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_idex,
  input  logic [REG_ADDR_W-1:0] Rs2_idex,
  input  logic                  reg_write_en_exmem,
  input  logic [REG_ADDR_W-1:0] Rd_exmem,
  input  logic                  reg_write_en_memwb,
  input  logic [REG_ADDR_W-1:0] Rd_memwb,
  output logic [1:0]            forward_A,
  output logic [1:0]            forward_B,
  output logic [CNT_W-1:0]      fwd_exmem_count,
  output logic [CNT_W-1:0]      fwd_memwb_count
);

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs                 (Rs1_idex),
    .reg_write_en_exmem (reg_write_en_exmem),
    .rd_exmem           (Rd_exmem),
    .reg_write_en_memwb (reg_write_en_memwb),
    .rd_memwb           (Rd_memwb),
    .sel                (forward_A)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs                 (Rs2_idex),
    .reg_write_en_exmem (reg_write_en_exmem),
    .rd_exmem           (Rd_exmem),
    .reg_write_en_memwb (reg_write_en_memwb),
    .rd_memwb           (Rd_memwb),
    .sel                (forward_B)
  );

`ifdef FORWARDING_UNIT_STATS_EN

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic any_exmem;
  logic any_memwb;
  logic [CNT_W-1:0] exmem_cnt;
  logic [CNT_W-1:0] memwb_cnt;

  // Both operands hitting the same stage still count as one cycle.
  assign any_exmem = (forward_A == FWD_EXMEM) || (forward_B == FWD_EXMEM);
  assign any_memwb = (forward_A == FWD_MEMWB) || (forward_B == FWD_MEMWB);

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_cnt <= '0;
      memwb_cnt <= '0;
    end else begin
      if (any_exmem) exmem_cnt <= sat_inc(exmem_cnt);
      if (any_memwb) memwb_cnt <= sat_inc(memwb_cnt);
    end
  end

  assign fwd_exmem_count = exmem_cnt;
  assign fwd_memwb_count = memwb_cnt;

`else

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign fwd_exmem_count = '0;
  assign fwd_memwb_count = '0;

`endif

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
// Testbench for forwarding_unit: table of combinational vectors plus
// clocked sequences for the statistics counters (default and CNT_W=4).
module tb_forwarding_unit;

`ifdef FORWARDING_UNIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rs1 = '0, rs2 = '0, rd_ex = '0, rd_wb = '0;
  logic       we_ex = 1'b0, we_wb = 1'b0;
  logic [1:0] fa, fb, fa4, fb4;
  logic [15:0] cnt_ex, cnt_wb;
  logic [3:0]  cnt4_ex, cnt4_wb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  forwarding_unit dut (
    .clk(clk), .rst(rst),
    .Rs1_idex(rs1), .Rs2_idex(rs2),
    .reg_write_en_exmem(we_ex), .Rd_exmem(rd_ex),
    .reg_write_en_memwb(we_wb), .Rd_memwb(rd_wb),
    .forward_A(fa), .forward_B(fb),
    .fwd_exmem_count(cnt_ex), .fwd_memwb_count(cnt_wb)
  );

  forwarding_unit #(.REG_ADDR_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .Rs1_idex(rs1), .Rs2_idex(rs2),
    .reg_write_en_exmem(we_ex), .Rd_exmem(rd_ex),
    .reg_write_en_memwb(we_wb), .Rd_memwb(rd_wb),
    .forward_A(fa4), .forward_B(fb4),
    .fwd_exmem_count(cnt4_ex), .fwd_memwb_count(cnt4_wb)
  );

  typedef struct {
    string      name;
    logic [3:0] rs1, rs2;
    logic       we_ex;
    logic [3:0] rd_ex;
    logic       we_wb;
    logic [3:0] rd_wb;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                        input logic wex, input logic [3:0] dex,
                        input logic wwb, input logic [3:0] dwb);
    rs1 = a; rs2 = b; we_ex = wex; rd_ex = dex; we_wb = wwb; rd_wb = dwb;
  endtask

  function automatic int exp_cnt(input int n);
    return STATS ? n : 0;
  endfunction

  initial begin
    vecs.push_back('{"no_write",       4'd1, 4'd2, 1'b0, 4'd1, 1'b0, 4'd2, 2'b00, 2'b00});
    vecs.push_back('{"exmem_a",        4'd1, 4'd2, 1'b1, 4'd1, 1'b0, 4'd0, 2'b01, 2'b00});
    vecs.push_back('{"exmem_b",        4'd1, 4'd2, 1'b1, 4'd2, 1'b0, 4'd0, 2'b00, 2'b01});
    vecs.push_back('{"memwb_a",        4'd3, 4'd4, 1'b0, 4'd3, 1'b1, 4'd3, 2'b10, 2'b00});
    vecs.push_back('{"memwb_b",        4'd3, 4'd4, 1'b0, 4'd3, 1'b1, 4'd4, 2'b00, 2'b10});
    vecs.push_back('{"priority",       4'd5, 4'd6, 1'b1, 4'd5, 1'b1, 4'd5, 2'b01, 2'b00});
    vecs.push_back('{"r0_all",         4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 2'b00, 2'b00});
    vecs.push_back('{"r0_src",         4'd0, 4'd7, 1'b1, 4'd0, 1'b1, 4'd7, 2'b00, 2'b10});
    vecs.push_back('{"both_exmem",     4'd9, 4'd9, 1'b1, 4'd9, 1'b0, 4'd9, 2'b01, 2'b01});
    vecs.push_back('{"both_memwb",     4'd8, 4'd8, 1'b0, 4'd8, 1'b1, 4'd8, 2'b10, 2'b10});
    vecs.push_back('{"mixed",          4'd10,4'd11,1'b1, 4'd10,1'b1, 4'd11,2'b01, 2'b10});
    vecs.push_back('{"mixed_swap",     4'd11,4'd10,1'b1, 4'd10,1'b1, 4'd11,2'b10, 2'b01});
    vecs.push_back('{"we_off_match",   4'd12,4'd12,1'b0, 4'd12,1'b0, 4'd12,2'b00, 2'b00});
    vecs.push_back('{"ex_off_wb_on",   4'd13,4'd1, 1'b0, 4'd13,1'b1, 4'd13,2'b10, 2'b00});
    vecs.push_back('{"r15",            4'd15,4'd14,1'b1, 4'd15,1'b1, 4'd14,2'b01, 2'b10});

    foreach (vecs[i]) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].we_ex, vecs[i].rd_ex,
             vecs[i].we_wb, vecs[i].rd_wb);
      #1;
      check({vecs[i].name, "_A"}, int'(fa), int'(vecs[i].exp_a));
      check({vecs[i].name, "_B"}, int'(fb), int'(vecs[i].exp_b));
      check({vecs[i].name, "_A4"}, int'(fa4), int'(vecs[i].exp_a));
    end

    // Counter sequences
    set_in(4'd1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ex", int'(cnt_ex), 0);
    check("rst_wb", int'(cnt_wb), 0);
    check("rst_ex4", int'(cnt4_ex), 0);

    set_in(4'd1, 4'd2, 1'b1, 4'd1, 1'b0, 4'd0);
    repeat (3) tick();
    check("three_ex", int'(cnt_ex), exp_cnt(3));
    check("three_wb", int'(cnt_wb), 0);
    check("three_ex4", int'(cnt4_ex), exp_cnt(3));

    set_in(4'd1, 4'd1, 1'b1, 4'd1, 1'b0, 4'd0);
    tick();
    check("both_same_ex", int'(cnt_ex), exp_cnt(4));

    set_in(4'd1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd3);
    tick();
    check("split_ex", int'(cnt_ex), exp_cnt(5));
    check("split_wb", int'(cnt_wb), exp_cnt(1));

    set_in(4'd1, 4'd2, 1'b1, 4'd1, 1'b0, 4'd0);
    repeat (20) tick();
    check("long_ex", int'(cnt_ex), exp_cnt(25));
    check("sat_ex4", int'(cnt4_ex), exp_cnt(15));
    check("sat_wb4", int'(cnt4_wb), exp_cnt(1));

    rst = 1'b1;
    #1;
    check("fwdA_in_rst", int'(fa), 1);
    check("fwdB_in_rst", int'(fb), 0);
    tick();
    rst = 1'b0;
    check("rst_hz_ex", int'(cnt_ex), 0);
    check("rst_hz_wb", int'(cnt_wb), 0);
    check("rst_hz_ex4", int'(cnt4_ex), 0);

    tick();
    check("post_rst_ex", int'(cnt_ex), exp_cnt(1));
    check("post_rst_wb", int'(cnt_wb), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_forwarding_unit

// File: doc/forwarding_unit.md
FORWARDING_UNIT -- requirements
Module: forwarding_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 4: register-specifier width (16 architectural registers, R0..R15).
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 Rs1_idex  input  REG_ADDR_W  first source register of the instruction in ID/EX.
REQ-007 Rs2_idex  input  REG_ADDR_W  second source register of the instruction in ID/EX.
REQ-008 reg_write_en_exmem  input  1  instruction in EX/MEM writes a register.
REQ-009 Rd_exmem  input  REG_ADDR_W  destination register of the EX/MEM instruction.
REQ-010 reg_write_en_memwb  input  1  instruction in MEM/WB writes a register.
REQ-011 Rd_memwb  input  REG_ADDR_W  destination register of the MEM/WB instruction.
REQ-012 forward_A  output  2  operand-A source select.
REQ-013 forward_B  output  2  operand-B source select.
REQ-014 fwd_exmem_count  output  CNT_W  cycles with at least one operand forwarded from EX/MEM.
REQ-015 fwd_memwb_count  output  CNT_W  cycles with at least one operand forwarded from MEM/WB.

Function
REQ-016 Select encoding: 2'b00 register file, 2'b01 EX/MEM result, 2'b10 MEM/WB result; 2'b11 SHALL never be driven.
REQ-017 forward_A and forward_B SHALL be purely combinational from the six data inputs, with zero-cycle latency and no dependence on clk or rst.
REQ-018 For operand X (Rs1_idex -> forward_A, Rs2_idex -> forward_B): output 01 when reg_write_en_exmem=1, Rd_exmem!=0 and Rd_exmem==RsX.
REQ-019 Otherwise output 10 when reg_write_en_memwb=1, Rd_memwb!=0 and Rd_memwb==RsX.
REQ-020 Otherwise output 00.
REQ-021 EX/MEM SHALL take priority over MEM/WB when both match the same source.
REQ-022 R0 is hardwired zero: a source of 0 SHALL always yield 00, whatever the write enables and destinations.
REQ-023 The two operands SHALL be evaluated independently; both may forward in the same cycle, from the same stage or from different stages.
REQ-024 A matching destination with its write enable at 0 SHALL NOT cause forwarding.
REQ-025 Each rising edge with rst=0: fwd_exmem_count increments by 1 if forward_A==01 or forward_B==01; fwd_memwb_count increments by 1 if forward_A==10 or forward_B==10.
REQ-026 A cycle with both operands forwarding from the same stage SHALL increment that stage's counter by 1.
REQ-027 Counters SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-028 On a rising edge with rst=1, both counters SHALL clear to 0; this takes priority over any increment in that cycle.
REQ-029 Reset SHALL NOT affect forward_A or forward_B; they stay valid combinational functions of the inputs during reset.

Configuration
REQ-030 Macro FORWARDING_UNIT_STATS_EN defined: the counters in REQ-025..REQ-028 are implemented.
REQ-031 Macro not defined: no counter state is built, fwd_exmem_count and fwd_memwb_count remain ports tied to 0, and forwarding behaviour is unchanged.

Structure
REQ-032 The select encodings (FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10) and the zero-register constant SHALL reside in the shared pipeline package.
REQ-033 Per-operand select logic SHALL be one sub-module, fwd_select, instantiated once for each operand.
REQ-034 The statistics counters SHALL live in the top level, inside the FORWARDING_UNIT_STATS_EN guard.

Verification
REQ-035 Rs1=1, Rs2=2, both write enables 0 -> forward_A=00, forward_B=00.
REQ-036 EX/MEM wr=1, Rd_exmem=1, Rs1=1, Rs2=2 -> 01/00; then Rd_exmem=2 -> 00/01.
REQ-037 EX/MEM wr=0, MEM/WB wr=1, Rd_memwb=3, Rs1=3, Rs2=4 -> 10/00; then Rd_memwb=4 -> 00/10.
REQ-038 Both stages wr=1, Rd_exmem=Rd_memwb=5, Rs1=5, Rs2=6 -> 01/00 (EX/MEM priority).
REQ-039 Both stages wr=1, both Rd=0, Rs1=Rs2=0 -> 00/00.
REQ-040 Stats enabled: rst for 1 cycle -> counters 0; 3 cycles of the REQ-036 first case -> fwd_exmem_count=3 and fwd_memwb_count=0; with CNT_W=4, 20 such cycles -> saturates at 15; rst with an active hazard -> counters 0 on that edge.
